// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared types for the restoring divider
package divider_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;

endpackage

// File: rtl/restoring_divider_if.sv
// rtl/restoring_divider_if.sv - operand load / start / result bundle of the restoring divider
interface restoring_divider_if #(
   parameter int DATA_WIDTH = 8
) ();

   logic                  EA;
   logic                  EB;
   logic                  start;
   logic [DATA_WIDTH-1:0] A_in;
   logic [DATA_WIDTH-1:0] B_in;
   logic [DATA_WIDTH-1:0] Q_out;
   logic [DATA_WIDTH-1:0] R_out;
   logic                  QR_valid;
   logic                  busy;
   logic                  div_by_zero;

   modport master (
      output EA, EB, start, A_in, B_in,
      input  Q_out, R_out, QR_valid, busy, div_by_zero
   );

   modport slave (
      input  EA, EB, start, A_in, B_in,
      output Q_out, R_out, QR_valid, busy, div_by_zero
   );

endinterface

// File: rtl/restoring_divider_div_step.sv
// rtl/restoring_divider_div_step.sv - one combinational restoring iteration (shift in MSB, trial subtract)
module div_step #(
   parameter int DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0] rem,
   input  logic [DATA_WIDTH-1:0] quo,
   input  logic [DATA_WIDTH-1:0] dvs,
   output logic [DATA_WIDTH-1:0] rem_next,
   output logic [DATA_WIDTH-1:0] quo_next
);

   logic [DATA_WIDTH:0]   w_s;
   logic [DATA_WIDTH+1:0] w_d;
   logic                  w_fits;

   assign w_s = {rem, quo[DATA_WIDTH-1]};
   assign w_d = {1'b0, w_s} - {2'b00, dvs};
   // rem < dvs always holds, so a non-negative difference never reaches bit DATA_WIDTH
   assign w_fits = (w_d[DATA_WIDTH+1:DATA_WIDTH] == 2'b00);

   always_comb begin
      if (w_fits) begin
         rem_next = w_d[DATA_WIDTH-1:0];
         quo_next = {quo[DATA_WIDTH-2:0], 1'b1};
      end else begin
         rem_next = w_s[DATA_WIDTH-1:0];
         quo_next = {quo[DATA_WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/restoring_divider.sv
// rtl/restoring_divider.sv - iterative unsigned restoring divider, one quotient bit per clock
module restoring_divider
   import divider_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input logic                clk,
   input logic                rst,
   restoring_divider_if.slave bus
);

   localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(DATA_WIDTH - 1);

   div_state_t            r_state;
   div_state_t            w_state_next;

   logic [DATA_WIDTH-1:0] r_a;
   logic [DATA_WIDTH-1:0] r_b;
   logic [DATA_WIDTH-1:0] r_rem;
   logic [DATA_WIDTH-1:0] r_quo;
   logic [DATA_WIDTH-1:0] r_dvs;
   logic [CW-1:0]         r_cnt;
   logic [DATA_WIDTH-1:0] r_q;
   logic [DATA_WIDTH-1:0] r_r;
   logic                  r_valid;
   logic                  r_dbz;

   logic [DATA_WIDTH-1:0] w_rem_next;
   logic [DATA_WIDTH-1:0] w_quo_next;
   logic                  w_load;
   logic                  w_dbz_load;
   logic                  w_step;
   logic                  w_finish;
   logic                  w_dbz_finish;

   div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
      .rem      (r_rem),
      .quo      (r_quo),
      .dvs      (r_dvs),
      .rem_next (w_rem_next),
      .quo_next (w_quo_next)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      w_dbz_load   = 1'b0;
      w_step       = 1'b0;
      w_finish     = 1'b0;
      w_dbz_finish = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.start) begin
               if (r_b != '0) begin
                  w_load       = 1'b1;
                  w_state_next = RUN;
               end else begin
                  w_dbz_load   = 1'b1;
                  w_state_next = DONE;
               end
            end
         end
         RUN: begin
            w_step = 1'b1;
            if (r_cnt == LAST_CNT) begin
               w_finish     = 1'b1;
               w_state_next = IDLE;
            end
         end
         DONE: begin
            w_dbz_finish = 1'b1;
            w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   // Working copies (r_rem/r_quo/r_dvs) decouple an in-flight division from later EA/EB loads
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_rem   <= '0;
         r_quo   <= '0;
         r_dvs   <= '0;
         r_cnt   <= '0;
         r_q     <= '0;
         r_r     <= '0;
         r_valid <= 1'b0;
         r_dbz   <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if (bus.EA) r_a <= bus.A_in;
         if (bus.EB) r_b <= bus.B_in;
         if (w_load) begin
            r_rem <= '0;
            r_quo <= r_a;
            r_dvs <= r_b;
            r_cnt <= '0;
         end
         if (w_dbz_load) begin
            r_rem <= r_a;
            r_quo <= '1;
         end
         if (w_step) begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
            r_cnt <= r_cnt + 1'b1;
         end
         if (w_finish) begin
            r_q     <= w_quo_next;
            r_r     <= w_rem_next;
            r_dbz   <= 1'b0;
            r_valid <= 1'b1;
         end
         if (w_dbz_finish) begin
            r_q     <= r_quo;
            r_r     <= r_rem;
            r_dbz   <= 1'b1;
            r_valid <= 1'b1;
         end
      end
   end

   assign bus.Q_out       = r_q;
   assign bus.R_out       = r_r;
   assign bus.QR_valid    = r_valid;
   assign bus.div_by_zero = r_dbz;
   assign bus.busy        = (r_state != IDLE);

endmodule
